// File: rtl/mips_pkg.sv
// Shared MIPS opcode constants and MEM-stage access state encoding.
// No logic; pure declarations imported by control and memory-stage blocks.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_SB    = 6'b101000;

   localparam logic [3:0] BE_WORD  = 4'b1111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Decodes LW/SW/LB/SB, aligns load lanes (sign-extending bytes), builds store enables/data.
// Purely combinational, zero latency; no flow control of its own.
module mem_lane_align
   import mips_pkg::*;
(
   input  logic [5:0]  opcode_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] rdata_i,
   input  logic [31:0] store_data_i,
   output logic        is_load_o,
   output logic        is_store_o,
   output logic        misalign_o,
   output logic [31:0] load_data_o,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o
);

   logic       is_word;
   logic [7:0] lane;

   always_comb begin
      is_word     = (opcode_i == OP_LW) || (opcode_i == OP_SW);
      is_load_o   = (opcode_i == OP_LW) || (opcode_i == OP_LB);
      is_store_o  = (opcode_i == OP_SW) || (opcode_i == OP_SB);
      misalign_o  = is_word && (addr_lo_i != 2'b00);

      // little-endian: lane k lives in bits [8k+7:8k]
      lane        = 8'(rdata_i >> {addr_lo_i, 3'b000});
      load_data_o = is_word ? rdata_i : {{24{lane[7]}}, lane};

      be_o        = is_word ? BE_WORD : (4'b0001 << addr_lo_i);
      wdata_o     = is_word ? store_data_i : {4{store_data_i[7:0]}};
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: cache hits in 0 cycles, single-word refill on miss, write-through stores.
// Stalls the pipeline from detection through mem_ack; stores add one unstalled DONE cycle before IDLE.
module mem_access_ctrl
   import mips_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic [31:0]      inst_MEM,
   input  logic [31:0]      addr,
   input  logic [31:0]      store_data,
   input  logic             cache_hit,
   input  logic [31:0]      cache_rdata,
   output logic             cache_fill_we,
   output logic             cache_we,
   output logic [3:0]       cache_be,
   output logic [31:0]      cache_wdata,
   output logic             mem_req,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [3:0]       mem_be,
   output logic [31:0]      mem_wdata,
   input  logic             mem_ack,
   input  logic [31:0]      mem_rdata,
   output logic [31:0]      load_data,
   output logic             reg_write_mem,
   output logic             stall,
   output logic             hit,
   output logic             addr_err,
   output logic [CNT_W-1:0] access_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   mem_state_t       state_q, state_d;
   logic [CNT_W-1:0] access_cnt_q, access_cnt_d;
   logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

   logic        is_load, is_store, misalign;
   logic [31:0] aligned_load, aligned_wdata;
   logic [3:0]  lane_be;
   logic        ld_ok, st_ok;

   // refill data goes straight from memory into the cache; only the opcode field is decoded here
   logic unused_inputs;
   assign unused_inputs = ^{inst_MEM[25:0], mem_rdata};

   mem_lane_align u_align (
      .opcode_i     (inst_MEM[31:26]),
      .addr_lo_i    (addr[1:0]),
      .rdata_i      (cache_rdata),
      .store_data_i (store_data),
      .is_load_o    (is_load),
      .is_store_o   (is_store),
      .misalign_o   (misalign),
      .load_data_o  (aligned_load),
      .be_o         (lane_be),
      .wdata_o      (aligned_wdata)
   );

   assign ld_ok = is_load && !misalign;
   assign st_ok = is_store && !misalign;

   always_comb begin
      state_d       = state_q;
      access_cnt_d  = access_cnt_q;
      miss_cnt_d    = miss_cnt_q;
      hit           = 1'b0;
      reg_write_mem = 1'b0;
      stall         = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      cache_fill_we = 1'b0;
      cache_we      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ld_ok && cache_hit) begin
               hit           = 1'b1;
               reg_write_mem = 1'b1;
               access_cnt_d  = access_cnt_q + 1'b1;
            end else if (ld_ok) begin
               stall      = 1'b1;
               miss_cnt_d = miss_cnt_q + 1'b1;
               state_d    = FILL;
            end else if (st_ok) begin
               stall   = 1'b1;
               state_d = WRITE;
            end
         end
         FILL: begin
            mem_req = 1'b1;
            stall   = 1'b1;
            if (mem_ack) begin
               cache_fill_we = 1'b1;
               state_d       = IDLE;
            end
         end
         WRITE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            stall   = 1'b1;
            if (mem_ack) begin
               cache_we     = cache_hit;
               access_cnt_d = access_cnt_q + 1'b1;
               state_d      = DONE;
            end
         end
         DONE: begin
            // the store is still in inst_MEM here; leaving unconditionally avoids re-issuing it
            state_d = IDLE;
         end
      endcase
      // outputs that act on the pipeline or memory are forced quiet while reset is held
      if (!rst_b) begin
         hit           = 1'b0;
         reg_write_mem = 1'b0;
         stall         = 1'b0;
         mem_req       = 1'b0;
         mem_we        = 1'b0;
         cache_fill_we = 1'b0;
         cache_we      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q      <= IDLE;
         access_cnt_q <= '0;
         miss_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         access_cnt_q <= access_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end

   assign addr_err    = misalign && rst_b;
   assign load_data   = hit ? aligned_load : 32'h0;
   assign mem_addr    = (is_load || is_store) ? {addr[31:2], 2'b00} : 32'h0;
   assign mem_be      = is_store ? lane_be : 4'b0000;
   assign mem_wdata   = is_store ? aligned_wdata : 32'h0;
   assign cache_be    = mem_be;
   assign cache_wdata = mem_wdata;
   assign access_cnt  = access_cnt_q;
   assign miss_cnt    = miss_cnt_q;

endmodule
